// File: rtl/instr_queue_mi_pkg.sv
// Shared types for the multi-issue instruction queue: control-flow kinds, queue entries
// and the decode-facing fetch entry.
package instr_queue_mi_pkg;

  localparam int unsigned VLEN = 39;
  localparam logic [63:0] INSTR_PAGE_FAULT = 64'd12;

  typedef enum logic [2:0] {NoCF, Branch, Jump, JumpR, Return} cf_t;

  typedef struct packed {
    cf_t             cf;
    logic [VLEN-1:0] predict_address;
  } branchpredict_sbe_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [VLEN-1:0]    address;
    logic [31:0]        instruction;
    branchpredict_sbe_t branch_predict;
    exception_t         ex;
  } fetch_entry_t;

  typedef struct packed {
    logic [31:0]     instr;
    cf_t             cf;
    logic            ex;
    logic [VLEN-1:0] pc;
    logic [VLEN-1:0] bp;
  } iq_entry_t;

  // Expand a compact stored entry into what decode consumes.
  function automatic fetch_entry_t to_fetch_entry(input iq_entry_t e);
    fetch_entry_t f;
    f.address                        = e.pc;
    f.instruction                    = e.instr;
    f.branch_predict.cf              = e.cf;
    f.branch_predict.predict_address = e.bp;
    f.ex.valid                       = e.ex;
    f.ex.cause                       = INSTR_PAGE_FAULT;
    f.ex.tval                        = 64'(e.pc);
    return f;
  endfunction

endpackage

// File: rtl/instr_queue_mi_compact.sv
// Combinational lane compactor: packs active lanes (valid & mask) in lane order into
// slots 0..n-1 and reports the source lane of each slot.
module instr_compact #(
  parameter int unsigned Lanes = 4,
  parameter int unsigned Width = 32,
  localparam int unsigned IdxW = (Lanes > 1) ? $clog2(Lanes) : 1,
  localparam int unsigned NW   = $clog2(Lanes + 1)
) (
  input  logic [Lanes-1:0]            i_valid,
  input  logic [Lanes-1:0]            i_mask,
  input  logic [Lanes-1:0][Width-1:0] i_lanes,
  output logic [Lanes-1:0][Width-1:0] o_slots,
  output logic [Lanes-1:0][IdxW-1:0]  o_slot_lane,
  output logic [NW-1:0]               o_n
);

  logic [Lanes-1:0] w_act;
  logic [NW-1:0]    w_pos;

  assign w_act = i_valid & i_mask;

  always_comb begin
    o_slots     = '0;
    o_slot_lane = '0;
    w_pos       = '0;
    for (int i = 0; i < Lanes; i++) begin
      if (w_act[i]) begin
        o_slots[w_pos[IdxW-1:0]]     = i_lanes[i];
        o_slot_lane[w_pos[IdxW-1:0]] = IdxW'(i);
        w_pos                        = w_pos + NW'(1);
      end
    end
    o_n = w_pos;
  end

endmodule

// File: rtl/instr_queue_mi.sv
// Multi-issue instruction queue: compacts a masked fetch packet into a circular entry array
// and presents up to ISSUE_WIDTH oldest entries, popped strictly in order.
module instr_queue_mi
  import instr_queue_mi_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = 4,
  parameter int unsigned ISSUE_WIDTH = 2,
  parameter int unsigned DEPTH       = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                flush_i,
  input  logic [FETCH_WIDTH-1:0][31:0]        instr_i,
  input  logic [FETCH_WIDTH-1:0][VLEN-1:0]    addr_i,
  input  logic [FETCH_WIDTH-1:0]              valid_i,
  input  cf_t  [FETCH_WIDTH-1:0]              cf_type_i,
  input  logic [VLEN-1:0]                     predict_address_i,
  input  logic                                exception_i,
  output logic                                ready_o,
  output logic [FETCH_WIDTH-1:0]              consumed_o,
  output logic                                replay_o,
  output logic [VLEN-1:0]                     replay_addr_o,
  output fetch_entry_t [ISSUE_WIDTH-1:0]      fetch_entry_o,
  output logic [ISSUE_WIDTH-1:0]              fetch_entry_valid_o,
  input  logic [ISSUE_WIDTH-1:0]              fetch_entry_ready_i
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned IdxW = $clog2(FETCH_WIDTH);
  localparam int unsigned NW   = $clog2(FETCH_WIDTH + 1);
  localparam int unsigned EntW = $bits(iq_entry_t);

  iq_entry_t                       r_mem [DEPTH];
  logic [PtrW-1:0]                 r_rd_ptr, r_wr_ptr;
  logic [CntW-1:0]                 r_count;

  logic [FETCH_WIDTH-1:0]          w_mask;
  iq_entry_t [FETCH_WIDTH-1:0]     w_lanes;
  iq_entry_t [FETCH_WIDTH-1:0]     w_slots;
  logic [FETCH_WIDTH-1:0][IdxW-1:0] w_slot_lane;
  logic [NW-1:0]                   w_n_raw;
  logic [CntW-1:0]                 w_n, w_free, w_k, w_pop;
  logic                            w_push_en;
  logic                            w_acc;

  // Keep lanes up to and including the first predicted-taken one.
  always_comb begin
    logic v_seen;
    v_seen = 1'b0;
    w_mask = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_mask[i] = !v_seen;
      if (cf_type_i[i] != NoCF) v_seen = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_lanes[i].instr = instr_i[i];
      w_lanes[i].cf    = cf_type_i[i];
      w_lanes[i].ex    = exception_i;
      w_lanes[i].pc    = addr_i[i];
      w_lanes[i].bp    = (cf_type_i[i] != NoCF) ? predict_address_i : '0;
    end
  end

  instr_compact #(
    .Lanes (FETCH_WIDTH),
    .Width (EntW)
  ) u_compact (
    .i_valid     (valid_i),
    .i_mask      (w_mask),
    .i_lanes     (w_lanes),
    .o_slots     (w_slots),
    .o_slot_lane (w_slot_lane),
    .o_n         (w_n_raw)
  );

  assign w_n       = CntW'(w_n_raw);
  assign w_free    = CntW'(DEPTH) - r_count;
  assign w_k       = (w_n < w_free) ? w_n : w_free;
  assign w_push_en = rst_ni & ~flush_i;
  assign ready_o   = (w_free >= CntW'(FETCH_WIDTH));

  always_comb begin
    consumed_o    = '0;
    replay_o      = 1'b0;
    replay_addr_o = '0;
    if (w_push_en) begin
      for (int s = 0; s < FETCH_WIDTH; s++) begin
        if (CntW'(s) < w_k) consumed_o[w_slot_lane[s]] = 1'b1;
      end
      if (w_k < w_n) begin
        replay_o = 1'b1;
        for (int s = 0; s < FETCH_WIDTH; s++) begin
          if (CntW'(s) == w_k) replay_addr_o = w_slots[s].pc;
        end
      end
    end
  end

  // A port only pops if every older port popped too.
  always_comb begin
    w_pop = '0;
    w_acc = 1'b1;
    for (int j = 0; j < ISSUE_WIDTH; j++) begin
      fetch_entry_valid_o[j] = (r_count > CntW'(j));
      fetch_entry_o[j]       = to_fetch_entry(r_mem[r_rd_ptr + PtrW'(j)]);
      w_acc = w_acc & fetch_entry_valid_o[j] & fetch_entry_ready_i[j];
      if (w_acc) w_pop = w_pop + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + w_pop[PtrW-1:0];
      r_wr_ptr <= r_wr_ptr + w_k[PtrW-1:0];
      r_count  <= r_count + w_k - w_pop;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int s = 0; s < FETCH_WIDTH; s++) begin
      if (w_push_en && (CntW'(s) < w_k)) r_mem[r_wr_ptr + PtrW'(s)] <= w_slots[s];
    end
  end

endmodule

// File: tb/tb_instr_queue_mi.sv
// Randomised and directed bench for instr_queue_mi against a queue-based reference model.
module tb_instr_queue_mi;
  import instr_queue_mi_pkg::*;

  localparam int FW    = 4;
  localparam int IW    = 2;
  localparam int DEPTH = 8;

  logic                     clk = 1'b0;
  logic                     rst_n, flush, exc;
  logic [FW-1:0][31:0]      instr;
  logic [FW-1:0][VLEN-1:0]  addr;
  logic [FW-1:0]            valid;
  cf_t  [FW-1:0]            cf;
  logic [VLEN-1:0]          predict;
  logic [IW-1:0]            rdy;
  logic                     ready_o, replay_o;
  logic [FW-1:0]            consumed_o;
  logic [VLEN-1:0]          replay_addr_o;
  fetch_entry_t [IW-1:0]    fe_o;
  logic [IW-1:0]            fe_valid_o;

  int n_vec = 0;
  int n_err = 0;
  fetch_entry_t mq[$];
  bit known = 1'b0;

  always #5 clk = ~clk;

  instr_queue_mi #(
    .FETCH_WIDTH (FW),
    .ISSUE_WIDTH (IW),
    .DEPTH       (DEPTH)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .flush_i             (flush),
    .instr_i             (instr),
    .addr_i              (addr),
    .valid_i             (valid),
    .cf_type_i           (cf),
    .predict_address_i   (predict),
    .exception_i         (exc),
    .ready_o             (ready_o),
    .consumed_o          (consumed_o),
    .replay_o            (replay_o),
    .replay_addr_o       (replay_addr_o),
    .fetch_entry_o       (fe_o),
    .fetch_entry_valid_o (fe_valid_o),
    .fetch_entry_ready_i (rdy)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_pkt(input logic [FW-1:0] v, input logic [VLEN-1:0] base);
    valid = v;
    for (int i = 0; i < FW; i++) begin
      addr[i]  = base + VLEN'(4 * i);
      instr[i] = $urandom;
      cf[i]    = NoCF;
    end
  endtask

  // Called at negedge+1 with inputs settled: check outputs, then advance the model.
  task automatic step();
    int lanes[$];
    bit taken_seen;
    int free, n, k, p;
    logic [FW-1:0] ec;
    logic [IW-1:0] ev;
    logic er;
    logic [VLEN-1:0] ea;
    fetch_entry_t e;
    if (!rst_n) begin
      check_eq("rst_consumed", 256'(consumed_o), 256'(0));
      check_eq("rst_replay", 256'(replay_o), 256'(0));
      mq.delete();
      known = 1'b1;
    end else begin
      taken_seen = 1'b0;
      for (int i = 0; i < FW; i++) begin
        if (!taken_seen && valid[i]) lanes.push_back(i);
        if (cf[i] != NoCF) taken_seen = 1'b1;
      end
      n    = lanes.size();
      free = DEPTH - mq.size();
      k    = (n < free) ? n : free;
      ec = '0; er = 1'b0; ea = '0;
      if (!flush) begin
        for (int s = 0; s < k; s++) ec[lanes[s]] = 1'b1;
        if (k < n) begin
          er = 1'b1;
          ea = addr[lanes[k]];
        end
      end
      if (known) begin
        check_eq("ready", 256'(ready_o), 256'(free >= FW));
        check_eq("consumed", 256'(consumed_o), 256'(ec));
        check_eq("replay", 256'(replay_o), 256'(er));
        check_eq("replay_addr", 256'(replay_addr_o), 256'(ea));
        for (int j = 0; j < IW; j++) ev[j] = (j < mq.size());
        check_eq("out_valid", 256'(fe_valid_o), 256'(ev));
        for (int j = 0; j < IW; j++)
          if (j < mq.size()) check_eq($sformatf("entry%0d", j), 256'(fe_o[j]), 256'(mq[j]));
      end
      p = 0;
      for (int j = 0; j < IW; j++)
        if (j < mq.size() && rdy[j] && p == j) p++;
      if (flush) mq.delete();
      else begin
        repeat (p) void'(mq.pop_front());
        for (int s = 0; s < k; s++) begin
          e.address                        = addr[lanes[s]];
          e.instruction                    = instr[lanes[s]];
          e.branch_predict.cf              = cf[lanes[s]];
          e.branch_predict.predict_address = (cf[lanes[s]] != NoCF) ? predict : '0;
          e.ex.valid                       = exc;
          e.ex.cause                       = 64'd12;
          e.ex.tval                        = 64'(addr[lanes[s]]);
          mq.push_back(e);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [IW-1:0] r);
    valid = '0;
    rdy   = r;
    #1;
    step();
  endtask

  initial begin
    logic [VLEN-1:0] base;
    rst_n = 1'b0; flush = 1'b0; exc = 1'b0; predict = '0; rdy = '0;
    set_pkt(4'hF, 'h40);
    @(negedge clk);
    #1; step();
    #1;
    check_eq("rst_valid_o", 256'(fe_valid_o), 256'(0));
    check_eq("rst_ready_o", 256'(ready_o), 256'(1));
    check_eq("rst_consumed_o", 256'(consumed_o), 256'(0));
    step();

    // Branch in lane 1 truncates the packet after it.
    rst_n = 1'b1;
    set_pkt(4'hF, 'h1000);
    cf[1] = Branch; predict = 'h80;
    #1;
    check_eq("br_consumed", 256'(consumed_o), 256'(4'b0011));
    check_eq("br_replay", 256'(replay_o), 256'(0));
    step();
    valid = '0; #1;
    check_eq("br_bp", 256'(fe_o[1].branch_predict.predict_address), 256'('h80));
    check_eq("br_cf", 256'(fe_o[1].branch_predict.cf), 256'(Branch));
    step();

    // Flush beats push and pop.
    flush = 1'b1; set_pkt(4'hF, 'h2000); rdy = 2'b11; #1;
    check_eq("fl_consumed", 256'(consumed_o), 256'(0));
    check_eq("fl_replay", 256'(replay_o), 256'(0));
    step();
    flush = 1'b0; valid = '0; rdy = '0; #1;
    check_eq("fl_valid_o", 256'(fe_valid_o), 256'(0));
    check_eq("fl_ready_o", 256'(ready_o), 256'(1));
    step();

    // Overflow at count 6.
    set_pkt(4'hF, 'h200); #1; step();
    set_pkt(4'b0011, 'h300); #1; step();
    set_pkt(4'hF, 'h100); #1;
    check_eq("ov_consumed", 256'(consumed_o), 256'(4'b0011));
    check_eq("ov_replay", 256'(replay_o), 256'(1));
    check_eq("ov_replay_addr", 256'(replay_addr_o), 256'('h108));
    step();
    valid = '0; #1;
    check_eq("ov_full_ready", 256'(ready_o), 256'(0));
    step();

    // In-order acceptance.
    flush = 1'b1; #1; step();
    flush = 1'b0;
    set_pkt(4'b0111, 'h400); #1; step();
    idle(2'b10);
    idle(2'b11);
    valid = '0; rdy = '0; #1;
    check_eq("ord_port0", 256'(fe_o[0].address), 256'('h408));
    step();

    // Wrap across index 7->0 with simultaneous push/pop.
    flush = 1'b1; #1; step();
    flush = 1'b0;
    set_pkt(4'hF, 'h500); #1; step();
    set_pkt(4'b0011, 'h510); #1; step();
    repeat (3) idle(2'b11);
    base = 'h600;
    for (int c = 0; c < 8; c++) begin
      set_pkt(4'hF, base);
      base += 16;
      rdy = 2'b11;
      #1; step();
    end

    // Random traffic, including occasional flush and mid-run reset.
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      flush = ($urandom_range(0, 29) == 0);
      exc   = ($urandom_range(0, 9) == 0);
      predict = VLEN'({$urandom, $urandom});
      set_pkt(4'($urandom), VLEN'($urandom));
      for (int i = 0; i < FW; i++)
        cf[i] = ($urandom_range(0, 3) == 0) ? cf_t'($urandom_range(1, 4)) : NoCF;
      rdy = 2'($urandom);
      #1; step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
